// File: rtl/conv_bram_pad_stride.sv
// conv_bram_pad_stride: zero-padded, strided multi-channel 2-D convolution reading image BRAMs
module conv_bram_pad_stride #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int IMG_D = 4,
  parameter int FILTER_W = 3,
  parameter int FILTER_H = 3,
  parameter int RESULT_D = 8,
  parameter int STRIDE_W = 1,
  parameter int STRIDE_H = 1,
  parameter int PAD = 1,
  parameter int RAM_LAT = 1,
  localparam int RESULT_W = (IMG_W + 2 * PAD - FILTER_W) / STRIDE_W + 1,
  localparam int RESULT_H = (IMG_H + 2 * PAD - FILTER_H) / STRIDE_H + 1,
  localparam int IMG_RAM_ADDR_WIDTH = $clog2(IMG_W * IMG_H),
  localparam int RESULT_RAM_ADDR_WIDTH = (RESULT_W * RESULT_H > 1) ? $clog2(RESULT_W * RESULT_H) : 1,
  localparam int RES_WIDTH = 4 * DATA_WIDTH
) (
  input  logic                                                   clk,
  input  logic                                                   reset,
  input  logic [DATA_WIDTH*RESULT_D*IMG_D*FILTER_H*FILTER_W-1:0] fil,
  input  logic                                                   val_in,
  output logic                                                   rdy_in,
  output logic [IMG_RAM_ADDR_WIDTH*IMG_D-1:0]                    img_rdaddress,
  input  logic [DATA_WIDTH*IMG_D-1:0]                            img_data_in,
  output logic [RESULT_RAM_ADDR_WIDTH*RESULT_D-1:0]              result_wraddress,
  output logic [RES_WIDTH*RESULT_D-1:0]                          result_data_out,
  output logic [RESULT_D-1:0]                                    result_wren,
  output logic                                                   done
);
  localparam int DW = DATA_WIDTH;
  localparam int RW = RES_WIDTH;
  localparam int AW = IMG_RAM_ADDR_WIDTH;
  localparam int WA = RESULT_RAM_ADDR_WIDTH;
  localparam int FT = FILTER_W * FILTER_H;
  localparam int TW = (FT > 1) ? $clog2(FT) : 1;
  localparam int CW = 16;
  localparam logic [CW-1:0] FW_M = CW'(FILTER_W - 1);
  localparam logic [CW-1:0] FH_M = CW'(FILTER_H - 1);
  localparam logic [CW-1:0] OW_M = CW'(RESULT_W - 1);
  localparam logic [CW-1:0] OH_M = CW'(RESULT_H - 1);
  localparam logic [CW-1:0] DR_M = CW'(RAM_LAT + 1);
  localparam logic [TW-1:0] FT_M = TW'(FT - 1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  typedef struct packed {
    logic          vld;
    logic          first;
    logic          last;
    logic          pad;
    logic [TW-1:0] tap;
    logic [WA-1:0] wa;
  } tag_t;
  state_t r_state, w_next;
  logic [CW-1:0] r_oh, r_ow, r_fh, r_fw, r_dcnt;
  logic [TW-1:0] r_tap;
  logic [AW-1:0] r_addr, w_lin;
  logic [WA-1:0] w_wa, r_m_wa;
  logic r_m_vld, r_m_first, r_m_last;
  tag_t r_tag [0:RAM_LAT];
  tag_t w_issue, w_ram;
  logic signed [31:0] w_iy, w_ix;
  logic w_pad, w_fw_end, w_fh_end, w_ow_end, w_oh_end, w_last, w_start;
  logic signed [DW-1:0] r_w [RESULT_D][IMG_D][FT];
  logic signed [DW-1:0] w_x [IMG_D];
  logic signed [RW-1:0] r_prod [RESULT_D][IMG_D];
  logic signed [RW-1:0] r_acc [RESULT_D];
  logic signed [RW-1:0] w_sum [RESULT_D];
  logic signed [RW-1:0] w_acc_nx [RESULT_D];
  assign w_start = r_state == IDLE && val_in;
  assign w_fw_end = r_fw == FW_M;
  assign w_fh_end = r_fh == FH_M;
  assign w_ow_end = r_ow == OW_M;
  assign w_oh_end = r_oh == OH_M;
  assign w_last = w_fw_end && w_fh_end && w_ow_end && w_oh_end;
  assign w_iy = $signed(32'(r_oh)) * STRIDE_H + $signed(32'(r_fh)) - PAD;
  assign w_ix = $signed(32'(r_ow)) * STRIDE_W + $signed(32'(r_fw)) - PAD;
  assign w_pad = w_iy < 0 || w_iy >= IMG_H || w_ix < 0 || w_ix >= IMG_W;
  assign w_lin = AW'(w_iy * IMG_W + w_ix);
  assign w_wa = WA'($signed(32'(r_oh)) * RESULT_W + $signed(32'(r_ow)));
  assign w_issue = '{vld: r_state == RUN, first: r_tap == '0, last: r_tap == FT_M, pad: w_pad, tap: r_tap, wa: w_wa};
  assign w_ram = r_tag[RAM_LAT];
  assign img_rdaddress = {IMG_D{r_addr}};
  assign result_wraddress = {RESULT_D{r_m_wa}};
  assign result_wren = {RESULT_D{r_m_vld && r_m_last}};
  // state register
  always_ff @(posedge clk) r_state <= !reset ? IDLE : w_next;
  // next state and handshake outputs
  always_comb begin
    w_next = r_state;
    rdy_in = r_state == IDLE;
    done = r_state == DONE;
    case (r_state)
      IDLE:    w_next = val_in ? RUN : IDLE;
      RUN:     w_next = w_last ? DRAIN : RUN;
      DRAIN:   w_next = r_dcnt == DR_M ? DONE : DRAIN;
      default: w_next = IDLE;
    endcase
  end
  // tap/window counters (fw innermost) and drain timer
  always_ff @(posedge clk) begin
    if (!reset || w_start) begin
      {r_oh, r_ow, r_fh, r_fw, r_dcnt} <= '0;
      r_tap <= '0;
    end else if (r_state == RUN) begin
      r_fw <= w_fw_end ? '0 : r_fw + CW'(1);
      r_tap <= (w_fw_end && w_fh_end) ? '0 : r_tap + TW'(1);
      if (w_fw_end) r_fh <= w_fh_end ? '0 : r_fh + CW'(1);
      if (w_fw_end && w_fh_end) r_ow <= w_ow_end ? '0 : r_ow + CW'(1);
      if (w_fw_end && w_fh_end && w_ow_end) r_oh <= w_oh_end ? '0 : r_oh + CW'(1);
      r_dcnt <= '0;
    end else if (r_state == DRAIN) r_dcnt <= r_dcnt + CW'(1);
  end
  // image read address, held over pad taps
  always_ff @(posedge clk) begin
    if (!reset) r_addr <= '0;
    else if (r_state == RUN && !w_pad) r_addr <= w_lin;
  end
  // weight snapshot taken when a start is accepted
  always_ff @(posedge clk) begin
    if (reset && w_start)
      for (int k = 0; k < RESULT_D; k++)
        for (int c = 0; c < IMG_D; c++)
          for (int t = 0; t < FT; t++) r_w[k][c][t] <= fil[((k * IMG_D + c) * FT + t) * DW +: DW];
  end
  // pad taps contribute zero regardless of what the BRAM returns
  always_comb begin
    for (int c = 0; c < IMG_D; c++) w_x[c] = w_ram.pad ? '0 : img_data_in[c * DW +: DW];
  end
  // tag delay line aligned to BRAM latency, then product stage
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i <= RAM_LAT; i++) r_tag[i] <= '0;
      {r_m_vld, r_m_first, r_m_last, r_m_wa} <= '0;
      for (int k = 0; k < RESULT_D; k++)
        for (int c = 0; c < IMG_D; c++) r_prod[k][c] <= '0;
    end else begin
      r_tag[0] <= w_issue;
      for (int i = 1; i <= RAM_LAT; i++) r_tag[i] <= r_tag[i-1];
      {r_m_vld, r_m_first, r_m_last, r_m_wa} <= {w_ram.vld, w_ram.first, w_ram.last, w_ram.wa};
      for (int k = 0; k < RESULT_D; k++)
        for (int c = 0; c < IMG_D; c++) r_prod[k][c] <= RW'(w_x[c]) * RW'(r_w[k][c][w_ram.tap]);
    end
  end
  // channel sum and next accumulator value (load on first tap of a window)
  always_comb begin
    for (int k = 0; k < RESULT_D; k++) begin
      w_sum[k] = '0;
      for (int c = 0; c < IMG_D; c++) w_sum[k] = w_sum[k] + r_prod[k][c];
      w_acc_nx[k] = r_m_first ? w_sum[k] : r_acc[k] + w_sum[k];
    end
  end
  // accumulators
  always_ff @(posedge clk) begin
    if (!reset) for (int k = 0; k < RESULT_D; k++) r_acc[k] <= '0;
    else if (r_m_vld) for (int k = 0; k < RESULT_D; k++) r_acc[k] <= w_acc_nx[k];
  end
  // result data is the accumulator value being committed this cycle
  always_comb begin
    result_data_out = '0;
    for (int k = 0; k < RESULT_D; k++) result_data_out[k * RW +: RW] = w_acc_nx[k];
  end
endmodule

// File: doc/conv_bram_pad_stride.md
Name: conv_bram_pad_stride

Overview:
- Parametrised 2-D convolution engine, successor to the fixed-geometry BRAM/shift-register conv core in conv_2d.
- Adds zero padding, independent W/H stride, configurable BRAM read latency, and a filter snapshot taken at start.
- Reads one image BRAM per input channel and computes RESULT_D output channels in parallel.
- Writes one output pixel per channel per window into per-channel result BRAMs, then pulses done.

Parameters:
- DATA_WIDTH, 8, signed pixel/weight width
- IMG_W, 8, image width
- IMG_H, 8, image height
- IMG_D, 4, input channels (one BRAM each)
- FILTER_W, 3, filter width
- FILTER_H, 3, filter height
- RESULT_D, 8, filters / output channels
- STRIDE_W, 1, horizontal stride
- STRIDE_H, 1, vertical stride
- PAD, 1, zero border on all four sides
- RAM_LAT, 1, image BRAM read latency in cycles (>=1)
- Derived, not set manually:
  - RESULT_W = (IMG_W+2*PAD-FILTER_W)/STRIDE_W+1
  - RESULT_H = (IMG_H+2*PAD-FILTER_H)/STRIDE_H+1
  - IMG_RAM_ADDR_WIDTH = $clog2(IMG_W*IMG_H)
  - RESULT_RAM_ADDR_WIDTH = $clog2(RESULT_W*RESULT_H)
  - RES_WIDTH = 4*DATA_WIDTH

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-low reset
- fil  input  DATA_WIDTH*RESULT_D*IMG_D*FILTER_H*FILTER_W  weights
  - index = ((k*IMG_D+c)*FILTER_H+fh)*FILTER_W+fw, LSB-first
- val_in  input  1  start request
- rdy_in  output  1  engine idle, accepts start
- img_rdaddress  output  IMG_RAM_ADDR_WIDTH*IMG_D  per-channel read address, all channels identical
- img_data_in  input  DATA_WIDTH*IMG_D  per-channel read data, valid RAM_LAT cycles after address
- result_wraddress  output  RESULT_RAM_ADDR_WIDTH*RESULT_D  per-channel write address
- result_data_out  output  RES_WIDTH*RESULT_D  per-channel result
- result_wren  output  RESULT_D  per-channel write enable
- done  output  1  one-cycle pulse after final write

Behaviour:
- Reset (reset==0 at a clk edge) aborts any operation from any state, including mid-run; no further writes are issued.
- Values after reset:
  - state=IDLE, rdy_in=1, done=0, result_wren=0
  - all addresses, result_data_out, accumulators and pipeline valids = 0
- FSM IDLE -> RUN -> DRAIN -> DONE -> IDLE.
- IDLE:
  - rdy_in=1.
  - On val_in&&rdy_in: snapshot fil into internal registers; clear counters oh=ow=fh=fw=0; go RUN.
  - Changes on fil after the snapshot have no effect until the next start.
- RUN:
  - rdy_in=0; val_in is ignored.
  - Issues one tap per cycle, fw innermost, then fh, then ow, then oh.
  - Tap coordinates: iy = oh*STRIDE_H+fh-PAD, ix = ow*STRIDE_W+fw-PAD, in signed arithmetic.
  - In-bounds tap (0<=ix<IMG_W and 0<=iy<IMG_H): img_rdaddress = iy*IMG_W+ix.
  - Out-of-bounds tap: the address holds its previous value and a pad flag travels with the tap; the data is forced to 0 when it emerges.
  - After the last tap of the last window, go DRAIN.
- Datapath pipeline (tag = first/last-of-window, pad flag, result address):
  - Tag delayed RAM_LAT cycles to align with img_data_in.
  - Stage M registers IMG_D*RESULT_D signed products (2*DATA_WIDTH, sign-extended to RES_WIDTH).
  - Stage A: for each k, sums the IMG_D products and adds them into acc[k].
  - acc[k] loads the sum instead of adding on the first tap of a window.
- Write-back:
  - On the cycle the last tap's sum is accumulated: result_wren=all ones, result_data_out[k]=final acc[k], result_wraddress[k]=ow+oh*RESULT_W for every k.
  - Last-tap issue to result_wren high: RAM_LAT+2 cycles.
  - result_wren is high for exactly one cycle per window.
- Arithmetic: two's complement, wraps modulo 2^RES_WIDTH, no saturation.
- Throughput: one window every FILTER_W*FILTER_H cycles, with no bubbles between windows.
- DRAIN:
  - Waits for the pipeline to empty (RAM_LAT+2 cycles), then goes DONE.
  - Total from start acceptance to done = RESULT_W*RESULT_H*FILTER_W*FILTER_H + RAM_LAT + 3 cycles.
- DONE: done=1 for one cycle; go IDLE; rdy_in=1 the following cycle.
- Boundary cases:
  - PAD=0 never produces a pad tap.
  - RESULT_W==1 or RESULT_H==1 is legal.
  - FILTER_W==FILTER_H==1 means every tap is both first and last of its window.

Test Plan:
- All-ones 4x4 image, IMG_D=1, RESULT_D=1, 3x3 all-ones filter, PAD=1, stride 1 -> 16 writes at addr 0..15; corners=4, edges=6, centre=9; done at cycle 16*9+RAM_LAT+3.
- 5x5 image with pixel=addr, PAD=0, STRIDE_W=STRIDE_H=2, 3x3 filter with only the centre weight=1 -> addr0..3 = 6, 8, 16, 18.
- IMG_D=2, RESULT_D=2, pixels 127, weights -1 (k=0) and +1 (k=1), 3x3, PAD=0 -> every k0 write = -2286 and every k1 write = +2286, both as 32-bit values.
- Change fil and pulse val_in repeatedly during RUN -> results unchanged from the snapshot; no restart; rdy_in stays 0 until after done.
- Assert reset=0 mid-RUN after 3 writes -> next cycle wren=0 and rdy_in=1; a new start produces the full result set from addr 0.
- RAM_LAT=2 with the first scenario's setup -> identical values; write timing shifted by +1 cycle.
